bcd_convert_scheduler: RTL and testbench

- Shares one sequential binary-to-BCD (double-dabble) engine between N_REQ requesters, e.g. PC, ALU result and register readback feeding the 7-segment display path.
- Round-robin arbitration picks one requester. The engine then performs one add-3/shift iteration per clock, and the block presents a registered packed-BCD result with a done pulse and the ID of the served requester.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_dabble_step.sv | 31 +++
 rtl/bcd_convert_scheduler.sv | 159 +++++++++++++++
 tb/tb_bcd_convert_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD conversion scheduler.
package bcd_pkg;

    // Scheduler FSM: wait for a request, then run the double-dabble iterations.
    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    // A digit at or above the threshold is corrected before the shift.
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Digit code the display path treats as blank.
    localparam logic [3:0] BCD_BLANK      = 4'hF;

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration: add-3 correction on every
// digit, then a one-bit left shift of the whole digit chain.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic [DIGITS*4-1:0] digits,
    input  logic                serial_in,
    output logic [DIGITS*4-1:0] digits_next,
    output logic                carry_out
);

    logic [DIGITS*4-1:0] adj;

    // Correct each digit independently; the largest corrected value is 12,
    // so the 4-bit sum never wraps.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (digits[gi*4 +: 4] >= BCD_ADJ_THRESH)
                                  ? digits[gi*4 +: 4] + BCD_ADJ_ADD
                                  : digits[gi*4 +: 4];
        end
    endgenerate

    // Shifting the packed chain moves each digit's bit 3 into the next
    // digit's bit 0; the serial operand bit enters the units digit.
    assign digits_next = {adj[DIGITS*4-2:0], serial_in};
    assign carry_out   = adj[DIGITS*4-1];

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Round-robin front end sharing one sequential double-dabble engine between
// several requesters. One iteration per clock, registered packed-BCD result.
module bcd_convert_scheduler
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8,
    parameter int N_REQ  = 2,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] value,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic [DIGITS*4-1:0]    bcd,
    output logic                   overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t                state_reg, state_next;
    logic [WIDTH-1:0]      operand_reg, operand_next;
    logic [DIGITS*4-1:0]   digits_reg, digits_next;
    logic                  ovf_acc_reg, ovf_acc_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [ID_W-1:0]       winner_reg, winner_next;
    logic [ID_W-1:0]       last_grant_reg, last_grant_next;
    logic [N_REQ-1:0]      grant_reg, grant_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic [ID_W-1:0]       done_id_reg, done_id_next;
    logic [DIGITS*4-1:0]   bcd_reg, bcd_next;
    logic                  overflow_reg, overflow_next;

    logic [ID_W-1:0]       win_idx;
    logic [ID_W-1:0]       cand;
    logic [DIGITS*4-1:0]   step_digits;
    logic                  step_carry;
    logic                  ovf_final;

    // The operand is shifted left every iteration, so its MSB is always the
    // next bit to feed in (MSB first).
    bcd_dabble_step #(
        .DIGITS (DIGITS)
    ) u_step (
        .digits      (digits_reg),
        .serial_in   (operand_reg[WIDTH-1]),
        .digits_next (step_digits),
        .carry_out   (step_carry)
    );

    assign ovf_final = ovf_acc_reg | step_carry;

    // Round-robin pick: scan downward so the closest requester after
    // last_grant is the one that survives.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = ID_W'((int'(last_grant_reg) + i) % N_REQ);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

    // Next-state and datapath control for the two-state scheduler.
    always_comb begin
        state_next      = state_reg;
        operand_next    = operand_reg;
        digits_next     = digits_reg;
        ovf_acc_next    = ovf_acc_reg;
        count_next      = count_reg;
        winner_next     = winner_reg;
        last_grant_next = last_grant_reg;
        grant_next      = '0;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        done_id_next    = done_id_reg;
        bcd_next        = bcd_reg;
        overflow_next   = overflow_reg;

        unique case (state_reg)
            IDLE: begin
                if (|req) begin
                    operand_next = value[win_idx*WIDTH +: WIDTH];
                    digits_next  = '0;
                    ovf_acc_next = 1'b0;
                    count_next   = '0;
                    winner_next  = win_idx;
                    grant_next   = N_REQ'(1) << win_idx;
                    busy_next    = 1'b1;
                    state_next   = CONVERT;
                end
            end
            CONVERT: begin
                operand_next = operand_reg << 1;
                digits_next  = step_digits;
                ovf_acc_next = ovf_final;
                count_next   = count_reg + 1'b1;
                if (count_reg == CNT_W'(WIDTH - 1)) begin
                    bcd_next        = ovf_final ? {DIGITS{BCD_BLANK}} : step_digits;
                    overflow_next   = ovf_final;
                    done_id_next    = winner_reg;
                    done_next       = 1'b1;
                    busy_next       = 1'b0;
                    last_grant_next = winner_reg;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset leaves requester 0 with top priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            operand_reg    <= '0;
            digits_reg     <= '0;
            ovf_acc_reg    <= 1'b0;
            count_reg      <= '0;
            winner_reg     <= '0;
            last_grant_reg <= ID_W'(N_REQ - 1);
            grant_reg      <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            done_id_reg    <= '0;
            bcd_reg        <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            operand_reg    <= operand_next;
            digits_reg     <= digits_next;
            ovf_acc_reg    <= ovf_acc_next;
            count_reg      <= count_next;
            winner_reg     <= winner_next;
            last_grant_reg <= last_grant_next;
            grant_reg      <= grant_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            done_id_reg    <= done_id_next;
            bcd_reg        <= bcd_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign grant    = grant_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign done_id  = done_id_reg;
    assign bcd      = bcd_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Randomized and directed bench for bcd_convert_scheduler, checked against a
// decimal-arithmetic reference model and a round-robin pointer model.
module tb_bcd_convert_scheduler;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 8;
    localparam int N_REQ  = 2;
    localparam int ID_W   = 1;

    logic                   clock;
    logic                   reset_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] value;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic [DIGITS*4-1:0]    bcd;
    logic                   overflow;

    int          vec_count;
    int          err_count;
    int          cyc;
    int          model_last;
    int          last_grant_cyc;
    bit          gap_valid;
    logic [31:0] last_bcd;

    bcd_convert_scheduler #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS),
        .N_REQ  (N_REQ),
        .ID_W   (ID_W)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .value    (value),
        .grant    (grant),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Decimal reference: digits by repeated division, blank on overflow.
    task automatic ref_bcd(input logic [31:0] v, output logic [31:0] b, output logic o);
        longint unsigned x;
        x = 64'(v);
        b = '0;
        o = 1'b0;
        if (x > 64'd99999999) begin
            b = 32'hFFFF_FFFF;
            o = 1'b1;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                b[i*4 +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
    endtask

    // Called at a negedge while the DUT is idle or in its done cycle.
    task automatic do_xfer(input logic [1:0] r, input logic [31:0] v0, input logic [31:0] v1,
                           input bit hold, input bit perturb);
        int          w;
        int          n;
        logic [1:0]  exp_g;
        logic [31:0] wv;
        logic [31:0] eb;
        logic        eo;
        req   = r;
        value = {v1, v0};
        w = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (r[(model_last + i) % N_REQ]) w = (model_last + i) % N_REQ;
        end
        exp_g = 2'b01 << w;
        wv    = (w == 0) ? v0 : v1;
        ref_bcd(wv, eb, eo);
        @(negedge clock);
        check_eq("grant", 64'(grant), 64'(exp_g));
        check_eq("busy_hi", 64'(busy), 64'd1);
        check_eq("done_lo", 64'(done), 64'd0);
        if (gap_valid) check_eq("grant_gap", 64'(cyc - last_grant_cyc), 64'd33);
        last_grant_cyc = cyc;
        if (!hold) req = '0;
        n = 0;
        while (!done && n < 40) begin
            if (perturb && n == 8) value = {$urandom(), $urandom()};
            if (n == 16) check_eq("bcd_hold", 64'(bcd), 64'(last_bcd));
            @(negedge clock);
            n++;
        end
        check_eq("latency", 64'(n), 64'd32);
        check_eq("done_id", 64'(done_id), 64'(w));
        check_eq("bcd", 64'(bcd), 64'(eb));
        check_eq("overflow", 64'(overflow), 64'(eo));
        check_eq("busy_lo", 64'(busy), 64'd0);
        $display("xfer req=%b winner=%0d value=%0d bcd=%h ovf=%0b", r, w, wv, eb, eo);
        model_last = w;
        last_bcd   = eb;
        gap_valid  = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        req     = '0;
        repeat (2) @(negedge clock);
        reset_n    = 1'b1;
        model_last = N_REQ - 1;
        last_bcd   = '0;
        gap_valid  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_grant"},   64'(grant),    64'd0);
        check_eq({tag, "_busy"},    64'(busy),     64'd0);
        check_eq({tag, "_done"},    64'(done),     64'd0);
        check_eq({tag, "_done_id"}, 64'(done_id),  64'd0);
        check_eq({tag, "_bcd"},     64'(bcd),      64'd0);
        check_eq({tag, "_ovf"},     64'(overflow), 64'd0);
    endtask

    initial begin
        int          seen;
        logic [1:0]  r;
        logic [31:0] v0;
        logic [31:0] v1;
        vec_count  = 0;
        err_count  = 0;
        cyc        = 0;
        gap_valid  = 1'b0;
        model_last = N_REQ - 1;
        last_bcd   = '0;
        last_grant_cyc = 0;
        reset_n    = 1'b0;
        req        = '0;
        value      = '0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Basic conversion, then back-to-back on requester 0.
        do_xfer(2'b01, 32'd12345678, 32'd0, 1'b0, 1'b0);
        @(negedge clock);
        gap_valid = 1'b0;
        do_xfer(2'b01, 32'd0, 32'd0, 1'b1, 1'b0);
        do_xfer(2'b01, 32'd99999999, 32'd0, 1'b0, 1'b0);
        // Overflow blanking and accumulator clearing.
        do_xfer(2'b01, 32'd100000000, 32'd0, 1'b0, 1'b0);
        do_xfer(2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        do_xfer(2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        do_xfer(2'b01, 32'd7, 32'd0, 1'b0, 1'b0);

        // Both requesting from reset: grants alternate 01,10,01.
        apply_reset();
        do_xfer(2'b11, 32'd5, 32'd7, 1'b1, 1'b0);
        do_xfer(2'b11, 32'd5, 32'd7, 1'b1, 1'b0);
        do_xfer(2'b11, 32'd5, 32'd7, 1'b0, 1'b0);

        // Value of the granted requester changed mid-conversion.
        do_xfer(2'b10, 32'd11, 32'd31415926, 1'b0, 1'b1);

        // Reset in the middle of a conversion.
        req   = 2'b01;
        value = {32'd0, 32'd123456};
        @(negedge clock);
        check_eq("pre_reset_grant", 64'(grant), 64'd1);
        req = '0;
        repeat (10) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clock);
        reset_n    = 1'b1;
        model_last = N_REQ - 1;
        last_bcd   = '0;
        gap_valid  = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) seen++;
        end
        check_eq("no_done_after_reset", 64'(seen), 64'd0);
        do_xfer(2'b01, 32'd42, 32'd0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 30; k++) begin
            r = 2'($urandom_range(1, 3));
            case ($urandom_range(0, 3))
                0: begin v0 = $urandom_range(0, 99);       v1 = $urandom_range(0, 99); end
                1: begin v0 = $urandom_range(0, 99999999); v1 = $urandom_range(0, 99999999); end
                2: begin v0 = $urandom();                  v1 = $urandom(); end
                default: begin v0 = 32'd99999999;          v1 = 32'd100000000; end
            endcase
            do_xfer(r, v0, v1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
